// File: rtl/ds1302_ctrl.sv
// DS1302 transaction sequencer upstream of a byte-level SPI master: CE framing, LSB-first bytes, polled BCD snapshot, host time-set.
// Optional DS1302_INIT_TIME_EN: after clearing write-protect, write INIT_SEC/INIT_MIN/INIT_HOUR before init_done.
module ds1302_ctrl #(
  parameter int unsigned SYS_CLK   = 50_000_000,
  parameter int unsigned POLL_HZ   = 10,
  parameter int unsigned CE_GUARD  = 200,
  parameter logic [7:0]  INIT_SEC  = 8'h00,
  parameter logic [7:0]  INIT_MIN  = 8'h00,
  parameter logic [7:0]  INIT_HOUR = 8'h00
) (
  input  logic       spi_clk,
  input  logic       spi_rst,
  output logic       spi_cs_ctrl,
  output logic       spi_wr_en,
  output logic [7:0] spi_data_in,
  input  logic [7:0] spi_data_out,
  input  logic       spi_wr_ack,
  input  logic       set_req,
  input  logic [7:0] set_sec,
  input  logic [7:0] set_min,
  input  logic [7:0] set_hour,
  output logic       set_busy,
  output logic       set_done,
  output logic [7:0] time_sec,
  output logic [7:0] time_min,
  output logic [7:0] time_hour,
  output logic       time_valid,
  output logic       init_done
);

  // CE_GUARD must be at least 2: hold counting starts at 1 on the last ack.
  localparam int unsigned PERIOD = SYS_CLK / POLL_HZ;
  localparam int unsigned TMR_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned GRD_W  = $clog2(CE_GUARD + 1);

  typedef enum logic [2:0] {
    SEQ_INIT_WP,
`ifdef DS1302_INIT_TIME_EN
    SEQ_INIT_TIME,
`endif
    SEQ_POLL_WAIT,
    SEQ_POLL,
    SEQ_SET
  } seq_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SETUP,
    TX_CMD_ACK,
    TX_TURN,
    TX_DATA_ACK,
    TX_HOLD,
    TX_GAP
  } tx_e;

  seq_e             seq_state;
  tx_e              tx_state;
  logic [1:0]       step;
  logic [GRD_W-1:0] grd_cnt;
  logic [TMR_W-1:0] poll_tmr;
  logic             tx_pend;
  logic             tx_done;
  logic             tx_rd;
  logic [7:0]       tx_cmd;
  logic [7:0]       tx_wdata;
  logic [7:0]       tx_rdata;
  logic [7:0]       sh_sec;
  logic [7:0]       sh_min;
  logic [7:0]       set_sec_q;
  logic [7:0]       set_min_q;
  logic [7:0]       set_hour_q;

  logic             tx_free_c;
  logic             launch_c;
  logic             rd_c;
  logic [7:0]       cmd_c;
  logic [7:0]       wdata_c;

  // The DS1302 shifts LSB first while the master shifts MSB first.
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  assign tx_free_c = (tx_state == TX_IDLE) && !tx_pend;

  // Command/data selection for the next transaction of the current sequencer step.
  always_comb begin
    launch_c = 1'b0;
    rd_c     = 1'b0;
    cmd_c    = 8'h00;
    case (step)
      2'd0:    wdata_c = set_sec_q;
      2'd1:    wdata_c = set_min_q;
      default: wdata_c = set_hour_q;
    endcase
    case (seq_state)
      SEQ_INIT_WP: begin
        launch_c = tx_free_c;
        cmd_c    = 8'h8E;
        wdata_c  = 8'h00;
      end
`ifdef DS1302_INIT_TIME_EN
      SEQ_INIT_TIME,
`endif
      SEQ_SET: begin
        launch_c = tx_free_c;
        cmd_c    = {5'b10000, step, 1'b0};
      end
      SEQ_POLL: begin
        launch_c = tx_free_c;
        cmd_c    = {5'b10000, step, 1'b1};
        rd_c     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge spi_clk) begin
    if (spi_rst) begin
      seq_state   <= SEQ_INIT_WP;
      tx_state    <= TX_IDLE;
      step        <= 2'd0;
      grd_cnt     <= '0;
      poll_tmr    <= '0;
      tx_pend     <= 1'b0;
      tx_done     <= 1'b0;
      tx_rd       <= 1'b0;
      tx_cmd      <= 8'h00;
      tx_wdata    <= 8'h00;
      tx_rdata    <= 8'h00;
      sh_sec      <= 8'h00;
      sh_min      <= 8'h00;
      // Set latches double as the INIT_TIME source until the first host set.
      set_sec_q   <= INIT_SEC & 8'h7F;
      set_min_q   <= INIT_MIN;
      set_hour_q  <= INIT_HOUR;
      spi_cs_ctrl <= 1'b0;
      spi_wr_en   <= 1'b0;
      spi_data_in <= 8'h00;
      set_busy    <= 1'b0;
      set_done    <= 1'b0;
      time_sec    <= 8'h00;
      time_min    <= 8'h00;
      time_hour   <= 8'h00;
      time_valid  <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      spi_wr_en  <= 1'b0;
      tx_done    <= 1'b0;
      time_valid <= 1'b0;
      set_done   <= 1'b0;

      // Byte engine: CE setup, command byte, data byte, CE hold, CE gap.
      case (tx_state)
        TX_IDLE: ;
        TX_SETUP: begin
          if (grd_cnt == GRD_W'(CE_GUARD - 1)) begin
            spi_wr_en   <= 1'b1;
            spi_data_in <= rev8(tx_cmd);
            tx_state    <= TX_CMD_ACK;
          end else begin
            grd_cnt <= grd_cnt + GRD_W'(1);
          end
        end
        TX_CMD_ACK: if (spi_wr_ack) tx_state <= TX_TURN;
        TX_TURN: begin
          spi_wr_en   <= 1'b1;
          spi_data_in <= tx_rd ? 8'h00 : rev8(tx_wdata);
          tx_state    <= TX_DATA_ACK;
        end
        TX_DATA_ACK: begin
          if (spi_wr_ack) begin
            if (tx_rd) tx_rdata <= rev8(spi_data_out);
            grd_cnt  <= GRD_W'(1);
            tx_state <= TX_HOLD;
          end
        end
        TX_HOLD: begin
          if (grd_cnt == GRD_W'(CE_GUARD - 1)) begin
            spi_cs_ctrl <= 1'b0;
            grd_cnt     <= '0;
            tx_state    <= TX_GAP;
          end else begin
            grd_cnt <= grd_cnt + GRD_W'(1);
          end
        end
        TX_GAP: begin
          if (grd_cnt == GRD_W'(CE_GUARD - 1)) begin
            tx_done  <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            grd_cnt <= grd_cnt + GRD_W'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase

      if (launch_c) begin
        tx_state    <= TX_SETUP;
        spi_cs_ctrl <= 1'b1;
        grd_cnt     <= '0;
        tx_cmd      <= cmd_c;
        tx_wdata    <= wdata_c;
        tx_rd       <= rd_c;
        tx_pend     <= 1'b1;
      end
      if (tx_done) tx_pend <= 1'b0;

      // Sequencer: advances one step per completed transaction.
      case (seq_state)
        SEQ_INIT_WP: begin
          if (tx_done) begin
            step <= 2'd0;
`ifdef DS1302_INIT_TIME_EN
            seq_state <= SEQ_INIT_TIME;
`else
            init_done <= 1'b1;
            seq_state <= SEQ_POLL;
`endif
          end
        end
`ifdef DS1302_INIT_TIME_EN
        SEQ_INIT_TIME: begin
          if (tx_done) begin
            if (step == 2'd2) begin
              init_done <= 1'b1;
              step      <= 2'd0;
              seq_state <= SEQ_POLL;
            end else begin
              step <= step + 2'd1;
            end
          end
        end
`endif
        SEQ_POLL_WAIT: begin
          if (set_req) begin
            set_sec_q  <= set_sec & 8'h7F;
            set_min_q  <= set_min;
            set_hour_q <= set_hour;
            set_busy   <= 1'b1;
            step       <= 2'd0;
            seq_state  <= SEQ_SET;
          end else if (poll_tmr == TMR_W'(PERIOD - 1)) begin
            step      <= 2'd0;
            seq_state <= SEQ_POLL;
          end else begin
            poll_tmr <= poll_tmr + TMR_W'(1);
          end
        end
        SEQ_POLL: begin
          poll_tmr <= '0;
          if (tx_done) begin
            case (step)
              2'd0: sh_sec <= tx_rdata;
              2'd1: sh_min <= tx_rdata;
              default: begin
                time_sec   <= sh_sec & 8'h7F;
                time_min   <= sh_min;
                time_hour  <= tx_rdata;
                time_valid <= 1'b1;
                seq_state  <= SEQ_POLL_WAIT;
              end
            endcase
            step <= (step == 2'd2) ? 2'd0 : step + 2'd1;
          end
        end
        SEQ_SET: begin
          if (tx_done) begin
            if (step == 2'd2) begin
              set_busy  <= 1'b0;
              set_done  <= 1'b1;
              step      <= 2'd0;
              seq_state <= SEQ_POLL;
            end else begin
              step <= step + 2'd1;
            end
          end
        end
        default: seq_state <= SEQ_INIT_WP;
      endcase
    end
  end

endmodule

// File: doc/ds1302_ctrl.md
# ds1302_ctrl

Transaction sequencer that sits directly upstream of the byte-level SPI master driving the DS1302 RTC. It owns chip-enable framing, command/data byte sequencing and LSB-first bit ordering. After reset it clears write-protect, then periodically reads seconds, minutes and hours into an atomic BCD snapshot. It also accepts host time-set requests between polls.

## Interface
- SYS_CLK, 50_000_000, spi_clk frequency in Hz
- POLL_HZ, 10, snapshot refresh rate; poll period = SYS_CLK/POLL_HZ cycles
- CE_GUARD, 200, cycles of CE setup before the first byte, CE hold after the last ack, and CE-low gap between transactions
- INIT_SEC / INIT_MIN / INIT_HOUR, 8'h00 / 8'h00 / 8'h00, BCD preset; used only with the macro below
- spi_clk  in  1  system clock
- spi_rst  in  1  reset, synchronous, active-high
- spi_cs_ctrl  out  1  CE request to master
- spi_wr_en  out  1  one-cycle byte start pulse to master
- spi_data_in  out  8  byte to master, bit-reversed
- spi_data_out  in  8  byte from master, bit-reversed
- spi_wr_ack  in  1  master byte-done pulse
- set_req  in  1  level request to write set_sec/set_min/set_hour
- set_sec, set_min, set_hour  in  8 each  BCD values to write
- set_busy  out  1  high from acceptance to completion of a set
- set_done  out  1  one-cycle pulse at set completion
- time_sec, time_min, time_hour  out  8 each  BCD snapshot; time_sec[7] forced 0 (CH masked)
- time_valid  out  1  one-cycle pulse on each snapshot update
- init_done  out  1  high once initialisation completes; sticky until reset

## Operation
- Transaction = CE_SETUP (CE=1, wait CE_GUARD) -> CMD (send command byte) -> DATA (send write byte or clock in read byte) -> CE_HOLD (wait CE_GUARD, CE still 1) -> CE_GAP (CE=0, wait CE_GUARD) -> return to sequencer.
- Bytes are sent with bit reversal: spi_data_in = reverse(byte). Read data = reverse(spi_data_out), captured on the DATA-byte ack. For reads, the DATA byte transmits 8'h00.
- Sequencer states: INIT_WP (write 8'h8E <- 8'h00), [INIT_TIME], POLL_WAIT, POLL (read 8'h81, 8'h83, 8'h85), SET (write 8'h80 <- {1'b0,set_sec[6:0]}, 8'h82 <- set_min, 8'h84 <- set_hour).
- set_* inputs are latched at acceptance.
- POLL: read bytes go to shadow registers. All three time_* outputs update together in the cycle after the hour read completes, with time_valid pulsed in that same cycle.
- Seconds-minute roll-over tearing between reads is accepted and not corrected.
- The first poll starts immediately after init. The poll timer counts only in POLL_WAIT and reloads on POLL entry.
- set_req is sampled only in POLL_WAIT. If it is asserted during init or a poll, it is held off until the poll completes; the requester holds it high.
- set_req together with timer expiry: SET wins. The poll runs immediately after SET.
- After SET, the sequencer goes to POLL so the snapshot reflects the new time.

## Timing
- spi_wr_en is a one-cycle pulse. spi_data_in is stable from spi_wr_en until spi_wr_ack.
- The next spi_wr_en is issued no earlier than 2 cycles after spi_wr_ack, so the master is back in IDLE.
- spi_cs_ctrl rises CE_GUARD cycles before the first spi_wr_en and falls CE_GUARD cycles after the last ack.
- Reset values: every output is 0, including spi_cs_ctrl, spi_wr_en, spi_data_in, time_*, time_valid, set_busy, set_done and init_done.
- Reset mid-transaction drops spi_cs_ctrl on the next edge. The master shares the same reset source; the top level inverts it for the master.
- set_busy rises the cycle after acceptance. set_done pulses in the cycle set_busy falls, which is after the hour write's CE_GAP.
- Poll timer width is $clog2(SYS_CLK/POLL_HZ). Period is measured from POLL_WAIT entry.

## Configuration
- DS1302_INIT_TIME_EN defined: INIT_TIME runs after INIT_WP and writes INIT_SEC with CH=0, then INIT_MIN, then INIT_HOUR, with the same encoding as SET. init_done rises after the hour write.
- Undefined: no INIT_TIME state is built, and init_done rises after INIT_WP. RTC contents are preserved across FPGA reset.

## Test plan
- Reset release with an RTC model holding 12:34:56 -> the first byte sent is reverse(8'h8E)=8'h71, then 8'h00. time_valid pulses with time_hour=8'h12, time_min=8'h34, time_sec=8'h56.
- RTC seconds = 8'hD6 (CH set) -> time_sec=8'h56.
- set_req=1 with 23:59:58 asserted during a poll -> accepted only after time_valid. Bytes sent are 80/58, 82/59, 84/23 (pre-reversal), followed by set_done and then a poll reading 23:59:58.
- Set request coinciding with timer expiry -> SET transactions precede the poll. Exactly one time_valid occurs after set_done.
- spi_rst asserted while CE=1 mid-byte -> spi_cs_ctrl=0 next cycle. After release, INIT_WP repeats.
- Define DS1302_INIT_TIME_EN with INIT 08:00:00 -> writes 80/00, 82/00, 84/08 before init_done rises.
